mem_resp_pipe: RTL and testbench



---
 rtl/mem_resp_pipe.sv | 82 ++++++++
 tb/tb_mem_resp_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mem_resp_pipe.sv
// Fixed-latency memory read-response pipeline over a single-port word store.
// Reads travel a LATENCY-deep {valid, addr, data} shift pipeline; writes update storage directly.
module mem_resp_pipe #(
    parameter int LATENCY = 4,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [15:0] resp_addr,
    output logic [3:0]  outstanding
);

    if (LATENCY < 2 || LATENCY > 8) begin : g_bad_latency
        $error("mem_resp_pipe: LATENCY must be in 2..8");
    end

    logic [15:0]         mem [2**AW];
    logic [AW-1:0]       word_idx;
    logic                rd_acc;
    logic                wr_acc;

    logic [LATENCY-1:0]  vld_q, vld_d;
    logic [15:0]         addr_q [LATENCY];
    logic [15:0]         addr_d [LATENCY];
    logic [15:0]         data_q [LATENCY];
    logic [15:0]         data_d [LATENCY];
    logic [3:0]          outstanding_q, outstanding_d;

    assign word_idx = addr[AW:1];
    assign rd_acc   = enable & ~wr;
    // Writes are gated by rst_n so storage ignores requests while held in reset.
    assign wr_acc   = enable & wr & rst_n;

    // Storage has no reset: its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[word_idx] <= data_in;
        end
    end

    // Empty slots carry zeros so the output stage is already 0 whenever data_valid is low.
    always_comb begin
        vld_d     = {vld_q[LATENCY-2:0], rd_acc};
        addr_d[0] = rd_acc ? (addr & 16'hFFFE) : 16'h0000;
        data_d[0] = rd_acc ? mem[word_idx]     : 16'h0000;
        for (int i = 1; i < LATENCY; i++) begin
            addr_d[i] = addr_q[i-1];
            data_d[i] = data_q[i-1];
        end
        outstanding_d = outstanding_q + {3'b000, rd_acc} - {3'b000, vld_q[LATENCY-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q         <= '0;
            outstanding_q <= 4'd0;
            for (int i = 0; i < LATENCY; i++) begin
                addr_q[i] <= 16'h0000;
                data_q[i] <= 16'h0000;
            end
        end else begin
            vld_q         <= vld_d;
            outstanding_q <= outstanding_d;
            for (int i = 0; i < LATENCY; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign data_valid  = vld_q[LATENCY-1];
    assign data_out    = data_q[LATENCY-1];
    assign resp_addr   = addr_q[LATENCY-1];
    assign outstanding = outstanding_q;

endmodule

// File: tb/tb_mem_resp_pipe.sv
// Bench for mem_resp_pipe: directed scenarios plus random traffic against a queue-based response model.
module tb_mem_resp_pipe;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        data_valid;
    logic [15:0] resp_addr;
    logic [3:0]  outstanding;

    mem_resp_pipe #(.LATENCY(LAT), .AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .resp_addr(resp_addr), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] a;
        logic [15:0] d;
    } resp_t;

    resp_t       q[$];
    logic [15:0] mem_m [256];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          peak = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic exp_v;
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        chk("data_valid", {15'd0, data_valid}, {15'd0, exp_v});
        chk("data_out", data_out, exp_v ? q[0].d : 16'h0000);
        chk("resp_addr", resp_addr, exp_v ? q[0].a : 16'h0000);
        chk("outstanding", {12'd0, outstanding}, 16'(q.size()));
    endtask

    // Apply one request, take one rising edge, update the model, check 1 time unit later.
    task automatic step(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        resp_t r;
        enable = en; wr = w; addr = a; data_in = d;
        @(posedge clk);
        cyc++;
        if (rst_n && en) begin
            if (w) begin
                mem_m[a[8:1]] = d;
            end else begin
                r.due = cyc + LAT - 1;
                r.a   = a & 16'hFFFE;
                r.d   = mem_m[a[8:1]];
                q.push_back(r);
            end
        end
        #1;
        while (q.size() > 0 && q[0].due < cyc) q.delete(0);
        if (int'(outstanding) > peak) peak = int'(outstanding);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        #2;
        chk("reset_valid", {15'd0, data_valid}, 16'h0000);
        chk("reset_data", data_out, 16'h0000);
        chk("reset_outstanding", {12'd0, outstanding}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Known contents everywhere so random reads have defined expectations.
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 16'(i * 2), 16'($urandom));

        // Write then read
        step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(2);
        chk("wr_rd_early", {15'd0, data_valid}, 16'h0000);
        idle(1);
        chk("wr_rd_data", data_out, 16'hBEEF);
        chk("wr_rd_addr", resp_addr, 16'h0010);
        idle(2);

        // Burst fill and read-back
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 16'(i * 2), 16'(16'h1000 + i));
        peak = 0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'(i * 2), 16'h0000);
        idle(LAT + 1);
        chk("burst_peak", 16'(peak), 16'd4);
        chk("burst_drain", {12'd0, outstanding}, 16'h0000);

        // In-flight read is not affected by a following write
        step(1'b1, 1'b1, 16'h0020, 16'h1111);
        step(1'b1, 1'b0, 16'h0020, 16'h0000);
        step(1'b1, 1'b1, 16'h0020, 16'h2222);
        idle(2);
        chk("inflight_old", data_out, 16'h1111);
        step(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(3);
        chk("inflight_new", data_out, 16'h2222);

        // Bubble and address wrap
        step(1'b1, 1'b1, 16'h0002, 16'h5A5A);
        step(1'b1, 1'b0, 16'h0202, 16'h0000);
        idle(1);
        step(1'b1, 1'b0, 16'h0002, 16'h0000);
        idle(1);
        chk("wrap_addr1", resp_addr, 16'h0202);
        chk("wrap_data1", data_out, 16'h5A5A);
        idle(1);
        chk("wrap_gap", {15'd0, data_valid}, 16'h0000);
        idle(1);
        chk("wrap_addr2", resp_addr, 16'h0002);
        chk("wrap_data2", data_out, 16'h5A5A);
        idle(1);

        // Reset mid-flight; a write presented during reset must be ignored
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'(i * 2), 16'h0000);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("midrst_valid", {15'd0, data_valid}, 16'h0000);
        chk("midrst_outstanding", {12'd0, outstanding}, 16'h0000);
        step(1'b1, 1'b1, 16'h0010, 16'hDEAD);
        rst_n = 1'b1;
        idle(LAT + 2);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(3);
        chk("post_rst_data", data_out, 16'hBEEF);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 16'($urandom), 16'($urandom));
        end
        idle(LAT + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
